pool_nxn_top: RTL and testbench
===============================

POOL_NXN_TOP -- requirements
Module: pool_nxn_top

Interface
REQ-001 SHALL have parameter LAYER_WIDTH, default 8, input feature-map width in pixels.
REQ-002 SHALL have parameter LAYER_HEIGHT, default 8, input feature-map height in pixels.
REQ-003 SHALL have parameter CHANNELS, default 1, number of feature maps stored back to back.
REQ-004 SHALL have parameter DATA_WIDTH, default 16, signed pixel width.
REQ-005 SHALL have parameter ADDR_WIDTH, default 16, read and write address width.
REQ-006 SHALL have parameter POOL_SIZE, default 2, window edge P; legal values are 2 and 4.
REQ-007 SHALL have parameter STRIDE, default 2, window step S; legal range is 1..POOL_SIZE.
REQ-008 SHALL have port clk, input, 1 bit, sole clock; all logic is rising-edge.
REQ-009 SHALL have port reset, input, 1 bit, asynchronous, active-high.
REQ-010 SHALL have port run, input, 1 bit, start pulse, sampled only in IDLE.
REQ-011 SHALL have port mode, input, 1 bit, 0 = max pooling, 1 = average pooling; sampled with run.
REQ-012 SHALL have port relu_en, input, 1 bit, applies ReLU to each result; sampled with run.
REQ-013 SHALL have port data_in, input, DATA_WIDTH bits, signed read data, valid one cycle after its address.
REQ-014 SHALL have port read_address_out, output, ADDR_WIDTH bits, input-memory read address.
REQ-015 SHALL have port result_out, output, DATA_WIDTH bits, signed pooled result.
REQ-016 SHALL have port write_address_out, output, ADDR_WIDTH bits, output-memory write address.
REQ-017 SHALL have port we_out, output, 1 bit, write strobe qualifying result_out and write_address_out.
REQ-018 SHALL have port busy, output, 1 bit, high whenever the FSM is not in IDLE.
REQ-019 SHALL have port done_out, output, 1 bit, one-cycle pulse after the final write.

Function
REQ-020 SHALL derive output dimensions OW = (LAYER_WIDTH-P)/S+1 and OH = (LAYER_HEIGHT-P)/S+1, using integer division.
REQ-021 SHALL locate channel c at base address c*LAYER_WIDTH*LAYER_HEIGHT.
REQ-022 SHALL process windows channel-major, then row-major, then column-major, with the top-left corner at (oy*S, ox*S).
REQ-023 SHALL implement FSM states IDLE, READ, DRAIN, WRITE, DONE with these transitions:
  - IDLE->READ on run.
  - READ->DRAIN after P*P read cycles.
  - DRAIN->WRITE.
  - WRITE->READ if windows remain, else WRITE->DONE.
  - DONE->IDLE.
REQ-024 SHALL, in READ, issue one address per cycle in window raster order: base + (y0+i)*LAYER_WIDTH + x0+j.
REQ-025 SHALL accumulate each returned sample one cycle after its address; DRAIN absorbs the final sample.
REQ-026 SHALL, in max mode, initialise the accumulator to the most negative value and keep the signed maximum.
REQ-027 SHALL, in average mode, sum in a DATA_WIDTH+2*log2(P)-bit signed accumulator and divide by P*P via arithmetic right shift (floor).
REQ-028 SHALL, when relu_en is set, replace a negative result with 0 before output.
REQ-029 SHALL, in WRITE, assert we_out for exactly one cycle, with result_out and write_address_out valid in that same cycle.
REQ-030 SHALL start write addresses at 0 and increment by 1 per write across all channels, for CHANNELS*OW*OH writes in total.
REQ-031 SHALL clear the accumulator on entry to READ, so no window contaminates the next.
REQ-032 SHALL take exactly P*P+2 cycles per window.
REQ-033 SHALL ignore run while busy, and SHALL not re-sample mode or relu_en mid-run.
REQ-034 SHALL pulse done_out in DONE and SHALL accept a new run in the following cycle.

Reset
REQ-035 SHALL, on reset assertion, immediately force the FSM to IDLE, all counters to 0, and every output to 0, including mid-run.
REQ-036 SHALL not resume an interrupted run after reset; a fresh run restarts at window 0 and write address 0.

Verification
REQ-037 SHALL cover: 4x4, C=1, P=2, S=2, max mode, data = address 0..15 -> writes 5, 7, 13, 15 at addresses 0..3, each window 6 cycles apart.
REQ-038 SHALL cover: the same configuration in average mode -> writes 2, 4, 10, 12; with data negated and relu_en=1 -> four writes of 0.
REQ-039 SHALL cover: 4x4, P=2, S=1, max mode -> 9 writes of 5, 6, 7, 9, 10, 11, 13, 14, 15; done_out pulses once, after the 9th write.
REQ-040 SHALL cover: 4x4, C=2, P=2, S=2, channel 1 data = 100+index -> writes 5, 7, 13, 15, 105, 107, 113, 115 at addresses 0..7.
REQ-041 SHALL cover: reset asserted during the second window -> all outputs 0 in the same cycle; a new run produces the full sequence from address 0.
REQ-042 SHALL cover: run pulsed while busy -> no effect; write count and done_out timing are unchanged.

Source files
------------

// File: rtl/pool_nxn_top.sv
// P x P max/average pooling engine with optional ReLU.
// Reads each window from a synchronous input memory (one-cycle read latency),
// reduces it, and writes one result per window to a linear output memory.
// Windows are visited channel by channel, row by row, column by column.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for run; mode and relu_en are captured with run
// ST_READ  | issuing P*P window addresses, accumulating returned samples
// ST_DRAIN | absorbing the last sample of the window, forming the result
// ST_WRITE | we_out high for one cycle with result and write address
// ST_DONE  | one-cycle done_out pulse, then back to idle
module pool_nxn_top #(
    parameter int LAYER_WIDTH  = 8,
    parameter int LAYER_HEIGHT = 8,
    parameter int CHANNELS     = 1,
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 16,
    parameter int POOL_SIZE    = 2,
    parameter int STRIDE       = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    input  logic                  mode,
    input  logic                  relu_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [ADDR_WIDTH-1:0] read_address_out,
    output logic [DATA_WIDTH-1:0] result_out,
    output logic [ADDR_WIDTH-1:0] write_address_out,
    output logic                  we_out,
    output logic                  busy,
    output logic                  done_out
);

    localparam int LOG2P = (POOL_SIZE == 4) ? 2 : 1;
    localparam int SHIFT = 2 * LOG2P;
    localparam int ACC_W = DATA_WIDTH + SHIFT;
    localparam int OW    = (LAYER_WIDTH - POOL_SIZE) / STRIDE + 1;
    localparam int OH    = (LAYER_HEIGHT - POOL_SIZE) / STRIDE + 1;

    localparam logic [1:0]            P_LAST  = 2'(POOL_SIZE - 1);
    localparam logic [ADDR_WIDTH-1:0] OW_LAST = ADDR_WIDTH'(OW - 1);
    localparam logic [ADDR_WIDTH-1:0] OH_LAST = ADDR_WIDTH'(OH - 1);
    localparam logic [ADDR_WIDTH-1:0] CH_LAST = ADDR_WIDTH'(CHANNELS - 1);
    localparam logic [ADDR_WIDTH-1:0] A_ROW   = ADDR_WIDTH'(LAYER_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] A_MAP   = ADDR_WIDTH'(LAYER_WIDTH * LAYER_HEIGHT);
    localparam logic [ADDR_WIDTH-1:0] A_STEP  = ADDR_WIDTH'(STRIDE);

    // Most negative DATA_WIDTH value, sign-extended to the accumulator width.
    localparam logic signed [ACC_W-1:0] ACC_MIN =
        {{(SHIFT + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_WRITE,
        ST_DONE
    } state_t;

    state_t                    r_state;
    logic                      r_mode;
    logic                      r_relu;
    logic                      r_sample_v;
    logic                      r_last;
    logic [1:0]                r_i;
    logic [1:0]                r_j;
    logic [ADDR_WIDTH-1:0]     r_ox;
    logic [ADDR_WIDTH-1:0]     r_oy;
    logic [ADDR_WIDTH-1:0]     r_ch;
    logic signed [ACC_W-1:0]   r_acc;
    logic [ADDR_WIDTH-1:0]     r_raddr;
    logic [ADDR_WIDTH-1:0]     r_waddr;
    logic [DATA_WIDTH-1:0]     r_result;
    logic                      r_we;
    logic                      r_busy;
    logic                      r_done;

    logic signed [ACC_W-1:0]   w_data_ext;
    logic signed [ACC_W-1:0]   w_acc_next;
    logic signed [ACC_W-1:0]   w_avg;
    logic signed [ACC_W-1:0]   w_pooled;
    logic [DATA_WIDTH-1:0]     w_result;
    logic [1:0]                w_i_next;
    logic [1:0]                w_j_next;
    logic                      w_read_last;
    logic                      w_unused_hi;

    // Address of element (i, j) of window (ox, oy) in channel ch.
    function automatic logic [ADDR_WIDTH-1:0] win_addr(
        input logic [ADDR_WIDTH-1:0] ch,
        input logic [ADDR_WIDTH-1:0] oy,
        input logic [ADDR_WIDTH-1:0] ox,
        input logic [1:0]            i,
        input logic [1:0]            j
    );
        logic [ADDR_WIDTH-1:0] ie;
        logic [ADDR_WIDTH-1:0] je;
        ie = {{(ADDR_WIDTH - 2){1'b0}}, i};
        je = {{(ADDR_WIDTH - 2){1'b0}}, j};
        return ch * A_MAP + (oy * A_STEP + ie) * A_ROW + ox * A_STEP + je;
    endfunction

    // Reduction datapath and in-window raster stepping.
    always_comb begin
        w_data_ext  = {{SHIFT{data_in[DATA_WIDTH-1]}}, data_in};
        w_acc_next  = r_acc;
        if (r_mode) begin
            w_acc_next = r_acc + w_data_ext;
        end else if (w_data_ext > r_acc) begin
            w_acc_next = w_data_ext;
        end
        // Arithmetic shift floors the average toward minus infinity.
        w_avg       = w_acc_next >>> SHIFT;
        w_pooled    = r_mode ? w_avg : w_acc_next;
        w_result    = (r_relu && w_pooled[ACC_W-1]) ? '0 : w_pooled[DATA_WIDTH-1:0];
        w_unused_hi = &{1'b0, w_pooled[ACC_W-2:DATA_WIDTH]};

        w_read_last = (r_i == P_LAST) && (r_j == P_LAST);
        w_j_next    = (r_j == P_LAST) ? 2'd0 : r_j + 2'd1;
        w_i_next    = (r_j == P_LAST) ? r_i + 2'd1 : r_i;
    end

    // Sequencer FSM; all outputs are registered here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_mode     <= 1'b0;
            r_relu     <= 1'b0;
            r_sample_v <= 1'b0;
            r_last     <= 1'b0;
            r_i        <= '0;
            r_j        <= '0;
            r_ox       <= '0;
            r_oy       <= '0;
            r_ch       <= '0;
            r_acc      <= '0;
            r_raddr    <= '0;
            r_waddr    <= '0;
            r_result   <= '0;
            r_we       <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_we       <= 1'b0;
            r_done     <= 1'b0;
            // Data returns one cycle after its address, so a sample is
            // pending exactly when the previous cycle was a read cycle.
            r_sample_v <= (r_state == ST_READ);
            if (r_sample_v) begin
                r_acc <= w_acc_next;
            end

            case (r_state)
                ST_IDLE: begin
                    if (run) begin
                        r_mode  <= mode;
                        r_relu  <= relu_en;
                        r_acc   <= mode ? '0 : ACC_MIN;
                        r_i     <= '0;
                        r_j     <= '0;
                        r_ox    <= '0;
                        r_oy    <= '0;
                        r_ch    <= '0;
                        r_raddr <= '0;
                        r_waddr <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_READ;
                    end
                end

                ST_READ: begin
                    if (w_read_last) begin
                        r_i     <= '0;
                        r_j     <= '0;
                        r_state <= ST_DRAIN;
                    end else begin
                        r_i     <= w_i_next;
                        r_j     <= w_j_next;
                        r_raddr <= win_addr(r_ch, r_oy, r_ox, w_i_next, w_j_next);
                    end
                end

                ST_DRAIN: begin
                    r_result <= w_result;
                    r_we     <= 1'b1;
                    r_last   <= (r_ox == OW_LAST) && (r_oy == OH_LAST) && (r_ch == CH_LAST);
                    // Step to the next window now so WRITE can issue its
                    // first address without extra combinational depth.
                    if (r_ox == OW_LAST) begin
                        r_ox <= '0;
                        if (r_oy == OH_LAST) begin
                            r_oy <= '0;
                            r_ch <= (r_ch == CH_LAST) ? '0 : r_ch + 1'b1;
                        end else begin
                            r_oy <= r_oy + 1'b1;
                        end
                    end else begin
                        r_ox <= r_ox + 1'b1;
                    end
                    r_state <= ST_WRITE;
                end

                ST_WRITE: begin
                    r_waddr <= r_waddr + 1'b1;
                    if (r_last) begin
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_acc   <= r_mode ? '0 : ACC_MIN;
                        r_raddr <= win_addr(r_ch, r_oy, r_ox, 2'd0, 2'd0);
                        r_state <= ST_READ;
                    end
                end

                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign read_address_out  = r_raddr;
    assign result_out        = r_result;
    assign write_address_out = r_waddr;
    assign we_out            = r_we;
    assign busy              = r_busy;
    assign done_out          = r_done;

endmodule

// File: tb/tb_pool_nxn_top.sv
// Directed bench for pool_nxn_top: three instances share one input memory.
//   inst 0: 4x4, C=1, P=2, S=2
//   inst 1: 4x4, C=1, P=2, S=1
//   inst 2: 4x4, C=2, P=2, S=2
module tb_pool_nxn_top;

    localparam int DW = 16;
    localparam int AW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst   [3];
    logic          run   [3];
    logic          mode  [3];
    logic          relu  [3];
    logic [DW-1:0] din   [3];
    logic [AW-1:0] raddr [3];
    logic [DW-1:0] res   [3];
    logic [AW-1:0] waddr [3];
    logic          we    [3];
    logic          busy  [3];
    logic          done  [3];

    logic signed [DW-1:0] mem [32];

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    int            cap_n  [3] = '{default: 0};
    logic [DW-1:0] cap_d  [3][32];
    logic [AW-1:0] cap_a  [3][32];
    int            cap_c  [3][32];
    int            done_n [3] = '{default: 0};
    int            done_c [3] = '{default: 0};

    pool_nxn_top #(.LAYER_WIDTH(4), .LAYER_HEIGHT(4), .CHANNELS(1), .DATA_WIDTH(DW),
                   .ADDR_WIDTH(AW), .POOL_SIZE(2), .STRIDE(2)) u_dut_s2 (
        .clk(clk), .reset(rst[0]), .run(run[0]), .mode(mode[0]), .relu_en(relu[0]),
        .data_in(din[0]), .read_address_out(raddr[0]), .result_out(res[0]),
        .write_address_out(waddr[0]), .we_out(we[0]), .busy(busy[0]), .done_out(done[0]));

    pool_nxn_top #(.LAYER_WIDTH(4), .LAYER_HEIGHT(4), .CHANNELS(1), .DATA_WIDTH(DW),
                   .ADDR_WIDTH(AW), .POOL_SIZE(2), .STRIDE(1)) u_dut_s1 (
        .clk(clk), .reset(rst[1]), .run(run[1]), .mode(mode[1]), .relu_en(relu[1]),
        .data_in(din[1]), .read_address_out(raddr[1]), .result_out(res[1]),
        .write_address_out(waddr[1]), .we_out(we[1]), .busy(busy[1]), .done_out(done[1]));

    pool_nxn_top #(.LAYER_WIDTH(4), .LAYER_HEIGHT(4), .CHANNELS(2), .DATA_WIDTH(DW),
                   .ADDR_WIDTH(AW), .POOL_SIZE(2), .STRIDE(2)) u_dut_c2 (
        .clk(clk), .reset(rst[2]), .run(run[2]), .mode(mode[2]), .relu_en(relu[2]),
        .data_in(din[2]), .read_address_out(raddr[2]), .result_out(res[2]),
        .write_address_out(waddr[2]), .we_out(we[2]), .busy(busy[2]), .done_out(done[2]));

    // Cycle counter and synchronous read ports (one-cycle latency).
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int n = 0; n < 3; n++) begin
            din[n] <= mem[raddr[n][4:0]];
        end
    end

    // Write and done capture, sampled mid-cycle.
    always @(negedge clk) begin
        for (int n = 0; n < 3; n++) begin
            if (we[n] === 1'b1 && cap_n[n] < 32) begin
                cap_d[n][cap_n[n]] <= res[n];
                cap_a[n][cap_n[n]] <= waddr[n];
                cap_c[n][cap_n[n]] <= cyc;
                cap_n[n]           <= cap_n[n] + 1;
            end
            if (done[n] === 1'b1) begin
                done_n[n] <= done_n[n] + 1;
                done_c[n] <= cyc;
            end
        end
    end

    task automatic set_mem(input logic neg);
        for (int k = 0; k < 16; k++) begin
            mem[k]      = neg ? DW'(-k) : DW'(k);
            mem[16 + k] = DW'(100 + k);
        end
    endtask

    task automatic start_run(input int n, input logic m, input logic r, output int rc);
        @(posedge clk); #1;
        mode[n] = m;
        relu[n] = r;
        run[n]  = 1'b1;
        @(posedge clk); #1;
        run[n]  = 1'b0;
        rc      = cyc;
    endtask

    task automatic wait_idle(input int n, input int budget);
        int k;
        k = 0;
        @(negedge clk); #1;
        while (busy[n] === 1'b1 && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        n_checks++;
        if (busy[n] !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_idle inst%0d: busy=%b after %0d cycles, required 0", n, busy[n], k);
        end
    endtask

    task automatic run_job(input int n, input logic m, input logic r,
                           output int base, output int dbase, output int rc);
        base  = cap_n[n];
        dbase = done_n[n];
        start_run(n, m, r, rc);
        wait_idle(n, 400);
    endtask

    task automatic test_reset();
        #2;
        for (int n = 0; n < 3; n++) rst[n] = 1'b1;
        #1;
        for (int n = 0; n < 3; n++) begin
            n_checks += 6;
            if (raddr[n] !== '0) begin n_fail++; $display("FAIL reset_raddr inst%0d: got %0h, required 0", n, raddr[n]); end
            if (waddr[n] !== '0) begin n_fail++; $display("FAIL reset_waddr inst%0d: got %0h, required 0", n, waddr[n]); end
            if (res[n]   !== '0) begin n_fail++; $display("FAIL reset_result inst%0d: got %0h, required 0", n, res[n]); end
            if (we[n]    !== 1'b0) begin n_fail++; $display("FAIL reset_we inst%0d: got %b, required 0", n, we[n]); end
            if (busy[n]  !== 1'b0) begin n_fail++; $display("FAIL reset_busy inst%0d: got %b, required 0", n, busy[n]); end
            if (done[n]  !== 1'b0) begin n_fail++; $display("FAIL reset_done inst%0d: got %b, required 0", n, done[n]); end
        end
        @(posedge clk); #1;
        for (int n = 0; n < 3; n++) rst[n] = 1'b0;
    endtask

    task automatic test_max_s2();
        int base, dbase, rc;
        int e[4];
        e = '{5, 7, 13, 15};
        set_mem(1'b0);
        run_job(0, 1'b0, 1'b0, base, dbase, rc);
        n_checks++;
        if (cap_n[0] - base !== 4) begin n_fail++; $display("FAIL max_s2_count: got %0d writes, required 4", cap_n[0] - base); end
        for (int k = 0; k < 4; k++) begin
            n_checks += 3;
            if (cap_d[0][base+k] !== DW'(e[k])) begin n_fail++; $display("FAIL max_s2_data[%0d]: got %0d, required %0d", k, $signed(cap_d[0][base+k]), e[k]); end
            if (cap_a[0][base+k] !== AW'(k)) begin n_fail++; $display("FAIL max_s2_addr[%0d]: got %0d, required %0d", k, cap_a[0][base+k], k); end
            if (cap_c[0][base+k] !== rc + 5 + 6 * k) begin n_fail++; $display("FAIL max_s2_cycle[%0d]: got %0d, required %0d", k, cap_c[0][base+k], rc + 5 + 6 * k); end
        end
        n_checks += 2;
        if (done_n[0] - dbase !== 1) begin n_fail++; $display("FAIL max_s2_done_count: got %0d, required 1", done_n[0] - dbase); end
        if (done_c[0] !== rc + 5 + 18 + 1) begin n_fail++; $display("FAIL max_s2_done_cycle: got %0d, required %0d", done_c[0], rc + 24); end
    endtask

    task automatic test_avg_relu();
        int base, dbase, rc;
        int   ev  [3][4];
        logic neg [3];
        logic rl  [3];
        ev  = '{'{2, 4, 10, 12}, '{-3, -5, -11, -13}, '{0, 0, 0, 0}};
        neg = '{1'b0, 1'b1, 1'b1};
        rl  = '{1'b0, 1'b0, 1'b1};
        for (int s = 0; s < 3; s++) begin
            set_mem(neg[s]);
            run_job(0, 1'b1, rl[s], base, dbase, rc);
            n_checks++;
            if (cap_n[0] - base !== 4) begin n_fail++; $display("FAIL avg_count s%0d: got %0d, required 4", s, cap_n[0] - base); end
            for (int k = 0; k < 4; k++) begin
                n_checks += 2;
                if (cap_d[0][base+k] !== DW'(ev[s][k])) begin n_fail++; $display("FAIL avg_data s%0d[%0d]: got %0d, required %0d", s, k, $signed(cap_d[0][base+k]), ev[s][k]); end
                if (cap_a[0][base+k] !== AW'(k)) begin n_fail++; $display("FAIL avg_addr s%0d[%0d]: got %0d, required %0d", s, k, cap_a[0][base+k], k); end
            end
        end
    endtask

    task automatic test_stride1();
        int base, dbase, rc;
        int e[9];
        e = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
        set_mem(1'b0);
        run_job(1, 1'b0, 1'b0, base, dbase, rc);
        n_checks++;
        if (cap_n[1] - base !== 9) begin n_fail++; $display("FAIL s1_count: got %0d writes, required 9", cap_n[1] - base); end
        for (int k = 0; k < 9; k++) begin
            n_checks += 2;
            if (cap_d[1][base+k] !== DW'(e[k])) begin n_fail++; $display("FAIL s1_data[%0d]: got %0d, required %0d", k, $signed(cap_d[1][base+k]), e[k]); end
            if (cap_a[1][base+k] !== AW'(k)) begin n_fail++; $display("FAIL s1_addr[%0d]: got %0d, required %0d", k, cap_a[1][base+k], k); end
        end
        n_checks += 2;
        if (done_n[1] - dbase !== 1) begin n_fail++; $display("FAIL s1_done_count: got %0d, required 1", done_n[1] - dbase); end
        if (done_c[1] !== cap_c[1][base+8] + 1) begin n_fail++; $display("FAIL s1_done_cycle: got %0d, required %0d", done_c[1], cap_c[1][base+8] + 1); end
    endtask

    task automatic test_channels();
        int base, dbase, rc;
        int e[8];
        e = '{5, 7, 13, 15, 105, 107, 113, 115};
        set_mem(1'b0);
        run_job(2, 1'b0, 1'b0, base, dbase, rc);
        n_checks++;
        if (cap_n[2] - base !== 8) begin n_fail++; $display("FAIL c2_count: got %0d writes, required 8", cap_n[2] - base); end
        for (int k = 0; k < 8; k++) begin
            n_checks += 2;
            if (cap_d[2][base+k] !== DW'(e[k])) begin n_fail++; $display("FAIL c2_data[%0d]: got %0d, required %0d", k, $signed(cap_d[2][base+k]), e[k]); end
            if (cap_a[2][base+k] !== AW'(k)) begin n_fail++; $display("FAIL c2_addr[%0d]: got %0d, required %0d", k, cap_a[2][base+k], k); end
        end
        n_checks++;
        if (done_n[2] - dbase !== 1) begin n_fail++; $display("FAIL c2_done_count: got %0d, required 1", done_n[2] - dbase); end
    endtask

    task automatic test_reset_midrun();
        int base, dbase, rc, k;
        int e[4];
        e = '{5, 7, 13, 15};
        set_mem(1'b0);
        base = cap_n[0];
        start_run(0, 1'b0, 1'b0, rc);
        k = 0;
        while (cap_n[0] == base && k < 50) begin
            @(negedge clk); #1;
            k++;
        end
        n_checks++;
        if (cap_n[0] !== base + 1) begin n_fail++; $display("FAIL rmid_first_write: got %0d writes, required 1", cap_n[0] - base); end
        @(negedge clk);
        @(negedge clk); #1;
        rst[0] = 1'b1;
        #1;
        n_checks += 6;
        if (raddr[0] !== '0) begin n_fail++; $display("FAIL rmid_raddr: got %0h, required 0", raddr[0]); end
        if (waddr[0] !== '0) begin n_fail++; $display("FAIL rmid_waddr: got %0h, required 0", waddr[0]); end
        if (res[0]   !== '0) begin n_fail++; $display("FAIL rmid_result: got %0h, required 0", res[0]); end
        if (we[0]    !== 1'b0) begin n_fail++; $display("FAIL rmid_we: got %b, required 0", we[0]); end
        if (busy[0]  !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b, required 0", busy[0]); end
        if (done[0]  !== 1'b0) begin n_fail++; $display("FAIL rmid_done: got %b, required 0", done[0]); end
        @(posedge clk); #1;
        rst[0] = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        n_checks += 2;
        if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL rmid_no_resume_busy: got %b, required 0", busy[0]); end
        if (cap_n[0] !== base + 1) begin n_fail++; $display("FAIL rmid_no_resume_writes: got %0d, required %0d", cap_n[0] - base, 1); end
        run_job(0, 1'b0, 1'b0, base, dbase, rc);
        n_checks++;
        if (cap_n[0] - base !== 4) begin n_fail++; $display("FAIL rmid_rerun_count: got %0d, required 4", cap_n[0] - base); end
        for (int i = 0; i < 4; i++) begin
            n_checks += 2;
            if (cap_d[0][base+i] !== DW'(e[i])) begin n_fail++; $display("FAIL rmid_rerun_data[%0d]: got %0d, required %0d", i, $signed(cap_d[0][base+i]), e[i]); end
            if (cap_a[0][base+i] !== AW'(i)) begin n_fail++; $display("FAIL rmid_rerun_addr[%0d]: got %0d, required %0d", i, cap_a[0][base+i], i); end
        end
    endtask

    task automatic test_run_while_busy();
        int base, dbase, rc;
        int e[9];
        e = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
        set_mem(1'b0);
        base  = cap_n[1];
        dbase = done_n[1];
        start_run(1, 1'b0, 1'b0, rc);
        repeat (3) @(posedge clk);
        #1;
        run[1] = 1'b1; mode[1] = 1'b1; relu[1] = 1'b1;
        @(posedge clk); #1;
        run[1] = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        run[1] = 1'b1;
        @(posedge clk); #1;
        run[1] = 1'b0;
        wait_idle(1, 400);
        repeat (10) @(posedge clk);
        #1;
        n_checks += 3;
        if (cap_n[1] - base !== 9) begin n_fail++; $display("FAIL busy_run_count: got %0d writes, required 9", cap_n[1] - base); end
        if (done_n[1] - dbase !== 1) begin n_fail++; $display("FAIL busy_run_done_count: got %0d, required 1", done_n[1] - dbase); end
        if (done_c[1] !== rc + 5 + 48 + 1) begin n_fail++; $display("FAIL busy_run_done_cycle: got %0d, required %0d", done_c[1], rc + 54); end
        for (int k = 0; k < 9; k++) begin
            n_checks++;
            if (cap_d[1][base+k] !== DW'(e[k])) begin n_fail++; $display("FAIL busy_run_data[%0d]: got %0d, required %0d", k, $signed(cap_d[1][base+k]), e[k]); end
        end
        mode[1] = 1'b0; relu[1] = 1'b0;
    endtask

    task automatic test_back_to_back();
        int base, dbase, rc, rc2;
        int e[4];
        e = '{5, 7, 13, 15};
        set_mem(1'b0);
        run_job(0, 1'b0, 1'b0, base, dbase, rc);
        // Now in the idle cycle right after the done pulse.
        run[0] = 1'b1;
        @(posedge clk); #1;
        run[0] = 1'b0;
        rc2  = cyc;
        base = cap_n[0];
        n_checks++;
        if (busy[0] !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: busy=%b, required 1", busy[0]); end
        wait_idle(0, 400);
        n_checks++;
        if (cap_n[0] - base !== 4) begin n_fail++; $display("FAIL b2b_count: got %0d, required 4", cap_n[0] - base); end
        for (int k = 0; k < 4; k++) begin
            n_checks += 3;
            if (cap_d[0][base+k] !== DW'(e[k])) begin n_fail++; $display("FAIL b2b_data[%0d]: got %0d, required %0d", k, $signed(cap_d[0][base+k]), e[k]); end
            if (cap_a[0][base+k] !== AW'(k)) begin n_fail++; $display("FAIL b2b_addr[%0d]: got %0d, required %0d", k, cap_a[0][base+k], k); end
            if (cap_c[0][base+k] !== rc2 + 5 + 6 * k) begin n_fail++; $display("FAIL b2b_cycle[%0d]: got %0d, required %0d", k, cap_c[0][base+k], rc2 + 5 + 6 * k); end
        end
    endtask

    initial begin
        for (int n = 0; n < 3; n++) begin
            rst[n] = 1'b0; run[n] = 1'b0; mode[n] = 1'b0; relu[n] = 1'b0;
        end
        set_mem(1'b0);
        test_reset();
        test_max_s2();
        test_avg_relu();
        test_stride1();
        test_channels();
        test_reset_midrun();
        test_run_while_busy();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
